// File: rtl/vec_control_seq_pkg.sv
// Shared definitions for the vector control sequencer: opcode and ALU
// operation encodings plus the packed control bundle carried per beat.
package vec_control_seq_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned ALUOP_W  = 4;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_EOR  = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_CMPJ = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_LSL  = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_LSRV = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_RORV = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_ROLV = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_LDV  = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_STV  = 5'd13;

    // ALU operation selects
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_EOR = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_LSL = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALU_LSR = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_ROR = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALU_ROL = 4'b0110;

    // Control bundle, field order fixed for all consumers
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               memread;
        logic               memtoreg;
        logic               memwrite;
        logic               regwrite;
        logic               jump;
        logic               illegal;
    } ctrl_t;

endpackage

// File: rtl/vec_control_seq_decode.sv
// Combinational opcode decoder for the vector control sequencer.
// Ports:
//   opcode    - instruction opcode
//   ctrl      - decoded control bundle (illegal set for undefined opcodes)
//   multibeat - instruction spans all beats of a vector; else a single beat
module vec_control_seq_decode
    import vec_control_seq_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                multibeat
);

    // Opcode to control field table
    always_comb begin
        ctrl      = '0;
        multibeat = 1'b0;
        case (opcode)
            OP_NOP: begin
                ctrl.aluop = ALU_ADD;
            end
            OP_EOR: begin
                ctrl.aluop    = ALU_EOR;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_SUB: begin
                ctrl.aluop    = ALU_SUB;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_ADD: begin
                ctrl.aluop    = ALU_ADD;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_CMPJ: begin
                ctrl.aluop    = ALU_SUB;
                ctrl.regwrite = 1'b1;
                ctrl.jump     = 1'b1;
            end
            OP_LSL: begin
                ctrl.aluop    = ALU_LSL;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_LSRV: begin
                ctrl.aluop    = ALU_LSR;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_RORV: begin
                ctrl.aluop    = ALU_ROR;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_ROLV: begin
                ctrl.aluop    = ALU_ROL;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_LDV: begin
                ctrl.aluop    = ALU_ADD;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                multibeat     = 1'b1;
            end
            OP_STV: begin
                ctrl.aluop    = ALU_ADD;
                ctrl.memwrite = 1'b1;
                multibeat     = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vec_control_seq.sv
// Sequenced vector control unit: accepts one instruction per handshake and
// emits a registered control bundle per beat (VLEN/LANES beats for vector
// ops, one beat for scalar-class ops), with backpressure and flush.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   in_valid/in_ready/in_opcode   - instruction handshake
//   flush                         - synchronous abort of current instruction
//   out_valid/out_ready           - bundle handshake
//   out_aluop..out_jump           - control fields, constant per instruction
//   out_beat/out_elem/out_last    - beat index, first element, final beat
//   out_illegal                   - undefined opcode
module vec_control_seq
    import vec_control_seq_pkg::*;
#(
    parameter  int unsigned VLEN  = 8,
    parameter  int unsigned LANES = 2,
    localparam int unsigned BEATS = VLEN / LANES,
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned EW    = $clog2(VLEN) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic                out_memread,
    output logic                out_memwrite,
    output logic                out_memtoreg,
    output logic                out_regwrite,
    output logic                out_jump,
    output logic [BW-1:0]       out_beat,
    output logic [EW-1:0]       out_elem,
    output logic                out_last,
    output logic                out_illegal
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [EW-1:0] elem_q, elem_d;
    logic          last_q, last_d;

    ctrl_t         dec_ctrl;
    logic          dec_multi;
    logic          advance;
    logic          accept;
    logic [BW-1:0] beat_inc;

    vec_control_seq_decode u_decode (
        .opcode    (in_opcode),
        .ctrl      (dec_ctrl),
        .multibeat (dec_multi)
    );

    assign out_valid = (state_q == ST_BUSY);
    assign advance   = out_valid && out_ready;
    // Ready also while the final beat drains, so back-to-back issue has no bubble
    assign in_ready  = !flush && ((state_q == ST_IDLE) || (advance && last_q));
    assign accept    = in_valid && in_ready;
    assign beat_inc  = beat_q + BW'(1);

    // Next-state: flush > new instruction > beat advance > hold
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        beat_d  = beat_q;
        elem_d  = elem_q;
        last_d  = last_q;
        if (flush) begin
            state_d = ST_IDLE;
            ctrl_d  = '0;
            beat_d  = '0;
            elem_d  = '0;
            last_d  = 1'b0;
        end else if (accept) begin
            state_d = ST_BUSY;
            ctrl_d  = dec_ctrl;
            beat_d  = '0;
            elem_d  = '0;
            last_d  = !dec_multi || (BEATS == 1);
        end else if (advance) begin
            if (last_q) begin
                state_d = ST_IDLE;
                ctrl_d  = '0;
                beat_d  = '0;
                elem_d  = '0;
                last_d  = 1'b0;
            end else begin
                beat_d = beat_inc;
                elem_d = EW'(beat_inc) * EW'(LANES);
                last_d = (beat_inc == BW'(BEATS - 1));
            end
        end
    end

    // State and bundle registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            beat_q  <= '0;
            elem_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            beat_q  <= beat_d;
            elem_q  <= elem_d;
            last_q  <= last_d;
        end
    end

    assign out_aluop    = ctrl_q.aluop;
    assign out_memread  = ctrl_q.memread;
    assign out_memwrite = ctrl_q.memwrite;
    assign out_memtoreg = ctrl_q.memtoreg;
    assign out_regwrite = ctrl_q.regwrite;
    assign out_jump     = ctrl_q.jump;
    assign out_illegal  = ctrl_q.illegal;
    assign out_beat     = (BEATS == 1) ? '0 : beat_q;
    assign out_elem     = elem_q;
    assign out_last     = last_q;

endmodule

// File: tb/tb_vec_control_seq.sv
// Self-checking bench for vec_control_seq (VLEN=8, LANES=2). A queue of
// expected beats is built from the opcode table on every accepted
// instruction and drained on every delivered beat.
module tb_vec_control_seq;

    localparam int VLEN  = 8;
    localparam int LANES = 2;
    localparam int NB    = VLEN / LANES;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_opcode;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_aluop;
    logic       out_memread, out_memwrite, out_memtoreg, out_regwrite;
    logic       out_jump, out_last, out_illegal;
    logic [1:0] out_beat;
    logic [3:0] out_elem;

    vec_control_seq #(.VLEN(VLEN), .LANES(LANES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_aluop    (out_aluop),
        .out_memread  (out_memread),
        .out_memwrite (out_memwrite),
        .out_memtoreg (out_memtoreg),
        .out_regwrite (out_regwrite),
        .out_jump     (out_jump),
        .out_beat     (out_beat),
        .out_elem     (out_elem),
        .out_last     (out_last),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int aluop;
        bit mr, mtr, mw, rw, j, il;
        int nb;
    } ref_t;

    typedef struct {
        int aluop;
        bit mr, mtr, mw, rw, j, il;
        int beat, elem;
        bit last;
    } beat_t;

    ref_t  tbl[16];
    beat_t q[$];
    int    total = 0;
    int    bad = 0;
    int    delivered = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ref_t lookup(input int op);
        ref_t r;
        r = '{op, 0, 0, 0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 16; i++)
            if (tbl[i].op == op) r = tbl[i];
        return r;
    endfunction

    task automatic push_instr(input int op);
        ref_t  r;
        beat_t b;
        r = lookup(op);
        for (int i = 0; i < r.nb; i++) begin
            b = '{r.aluop, r.mr, r.mtr, r.mw, r.rw, r.j, r.il, i, i * LANES, (i == r.nb - 1)};
            q.push_back(b);
        end
    endtask

    // One clock: drive inputs, check against the model at negedge, update model
    task automatic cycle(input bit iv, input int op, input bit ordy, input bit fl);
        bit    ev, er;
        beat_t h;
        in_valid  = iv;
        in_opcode = 5'(op);
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        ev = (q.size() != 0);
        er = !fl && ((q.size() == 0) || (q.size() == 1 && ordy));
        check("out_valid", int'(out_valid), int'(ev));
        check("in_ready", int'(in_ready), int'(er));
        if (ev) begin
            h = q[0];
            check("aluop", int'(out_aluop), h.aluop);
            check("memread", int'(out_memread), int'(h.mr));
            check("memtoreg", int'(out_memtoreg), int'(h.mtr));
            check("memwrite", int'(out_memwrite), int'(h.mw));
            check("regwrite", int'(out_regwrite), int'(h.rw));
            check("jump", int'(out_jump), int'(h.j));
            check("illegal", int'(out_illegal), int'(h.il));
            check("beat", int'(out_beat), h.beat);
            check("elem", int'(out_elem), h.elem);
            check("last", int'(out_last), int'(h.last));
        end else begin
            check("idle_fields", int'({out_aluop, out_memread, out_memtoreg, out_memwrite,
                  out_regwrite, out_jump, out_illegal, out_beat, out_elem, out_last}), 0);
        end
        if (ev && ordy) delivered++;
        if (fl) begin
            q.delete();
        end else begin
            if (ev && ordy) void'(q.pop_front());
            if (iv && er) push_instr(op);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        int d0;
        tbl[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{2,  2, 0, 0, 0, 1, 0, 0, NB};
        tbl[2]  = '{3,  1, 0, 0, 0, 1, 0, 0, NB};
        tbl[3]  = '{4,  0, 0, 0, 0, 1, 0, 0, NB};
        tbl[4]  = '{6,  1, 0, 0, 0, 1, 1, 0, 1};
        tbl[5]  = '{7,  3, 0, 0, 0, 1, 0, 0, NB};
        tbl[6]  = '{8,  4, 0, 0, 0, 1, 0, 0, NB};
        tbl[7]  = '{9,  5, 0, 0, 0, 1, 0, 0, NB};
        tbl[8]  = '{10, 6, 0, 0, 0, 1, 0, 0, NB};
        tbl[9]  = '{12, 0, 1, 1, 0, 1, 0, 0, NB};
        tbl[10] = '{13, 0, 0, 0, 1, 0, 0, 0, NB};
        tbl[11] = '{1,  0, 0, 0, 0, 0, 0, 1, 1};
        tbl[12] = '{5,  0, 0, 0, 0, 0, 0, 1, 1};
        tbl[13] = '{11, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[14] = '{14, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[15] = '{31, 0, 0, 0, 0, 0, 0, 1, 1};

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; flush = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_valid", int'(out_valid), 0);
        check("rst_aluop", int'(out_aluop), 0);
        check("rst_beat", int'(out_beat), 0);
        check("rst_last", int'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: each opcode alone, full drain
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, tbl[i].op, 1'b1, 1'b0);
            drain(tbl[i].nb);
        end

        // ldv under backpressure: exactly NB beats delivered
        cycle(1'b1, 12, 1'b1, 1'b0);
        d0 = delivered;
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("ldv_beats", delivered - d0, NB);
        drain(1);

        // cmpj then sub with no bubble
        cycle(1'b1, 6, 1'b1, 1'b0);
        cycle(1'b1, 3, 1'b1, 1'b0);
        drain(NB + 1);

        // illegal opcode then idle
        cycle(1'b1, 31, 1'b1, 1'b0);
        drain(2);

        // stv flushed at beat 1, then add from beat 0
        cycle(1'b1, 13, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);
        cycle(1'b1, 4, 1'b1, 1'b0);
        drain(NB + 1);

        // async reset mid-rolv at beat 2
        cycle(1'b1, 10, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("rolv_beat_before_rst", int'(out_beat), 2);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_aluop", int'(out_aluop), 0);
        check("async_beat", int'(out_beat), 0);
        q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drain(1);
        cycle(1'b1, 4, 1'b1, 1'b0);
        drain(NB);

        // randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        drain(NB + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
